// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the reset sequencer.
// State encoding is visible on the debug port, so values are fixed.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STABLE  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow status bits crossing into a clock domain.
// Resets to zero so downstream logic sees "not ready" until proven otherwise.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: qualifies clock lock, holds resets, then releases
// downstream domains one by one; any lock loss or soft reset restarts it.
module rst_seq_gen
  import clk_rst_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int MIN_HOLD    = 16,
  parameter int LOCK_STABLE = 8,
  parameter int STAGE_DLY   = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_system,
  input  logic             g_reset_n,
  input  logic             dcm_locked,
  input  logic             sw_reset,
  output logic [N_CH-1:0]  ch_rst_n,
  output logic             all_ready,
  output logic             lock_sync,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]       state_o
);

  localparam int HOLD_W = cnt_w(MIN_HOLD - 1);
  localparam int STAB_W = cnt_w(LOCK_STABLE - 1);
  localparam int GAP_W  = cnt_w(STAGE_DLY - 1);
  localparam int IDX_W  = cnt_w(N_CH - 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]   CH_ONE   = N_CH'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e            state_d, state_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic [STAB_W-1:0] stab_d, stab_q;
  logic [GAP_W-1:0]  gap_d, gap_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [N_CH-1:0]   ch_d, ch_q;
  logic              rdy_d, rdy_q;
  logic [CNT_W-1:0]  loss_d, loss_q;
  logic              lost;

  sync_2ff #(
    .W(1)
  ) u_lock_sync (
    .clk  (clk_system),
    .rst_n(g_reset_n),
    .d    (dcm_locked),
    .q    (lock_sync)
  );

  assign lost = ((state_q == ST_RELEASE) || (state_q == ST_RUN))
                && !lock_sync;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    ch_d    = ch_q;
    rdy_d   = rdy_q;
    loss_d  = loss_q;

    // Counted independently of sw_reset so lock events are never hidden.
    if (lost && (loss_q != CNT_MAX)) begin
      loss_d = loss_q + 1'b1;
    end

    if (sw_reset || lost) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      ch_d    = '0;
      rdy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
          if ((hold_q == HOLD_MAX) && lock_sync) begin
            state_d = ST_STABLE;
            stab_d  = '0;
          end
        end
        ST_STABLE: begin
          if (!lock_sync) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else if (stab_q == STAB_MAX) begin
            state_d = ST_RELEASE;
            ch_d    = CH_ONE;
            idx_d   = '0;
            gap_d   = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
          end else if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            rdy_d   = 1'b1;
          end else begin
            // Channels come out of reset in bit order, so shift in a one.
            ch_d  = (ch_q << 1) | CH_ONE;
            idx_d = idx_q + 1'b1;
            gap_d = '0;
          end
        end
        ST_RUN: begin
          rdy_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          hold_d  = '0;
          ch_d    = '0;
          rdy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_system or negedge g_reset_n) begin
    if (!g_reset_n) begin
      state_q <= ST_HOLD;
      hold_q  <= '0;
      stab_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      ch_q    <= '0;
      rdy_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
      rdy_q   <= rdy_d;
      loss_q  <= loss_d;
    end
  end

  assign ch_rst_n      = ch_q;
  assign all_ready     = rdy_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule
